// File: rtl/uart_pkg.sv
// Shared types and status-word layout for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  // Bit positions inside the status word returned to the core.
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_BUSY    = 3;
  localparam int ST_CNT_LSB = 8;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-around pointers; the extra pointer MSB tells
// full apart from empty when the index bits are equal.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  // Full/empty are judged on the registered pointers, before this cycle's traffic.
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;

  // Pointer update; reset discards all stored entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the core's store bus.
// Bytes stored to TX_ADDR are queued; the status word is muxed into ReadData
// by the top level whenever Sel is high.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = 32'hFFFF_0000,
  parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_0004,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        Sel,
  output logic [31:0] StatusData,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [BW-1:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shreg;
  logic        r_ovf;
  logic        r_tx;
  logic        r_busy;

  logic        w_hit_tx;
  logic        w_hit_st;
  logic        w_push_req;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic        w_pop;
  logic        w_shift;
  logic        w_baud_end;
  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_fifo_dout;
  logic [AW:0] w_count;
  logic [4:0]  w_cnt5;
  logic        w_unused_bits;

  assign w_hit_tx   = (DataAdr == TX_ADDR);
  assign w_hit_st   = (DataAdr == STATUS_ADDR);
  assign Sel        = w_hit_tx || w_hit_st;
  assign w_push_req = MemWrite && w_hit_tx;
  assign w_ovf_set  = w_push_req && w_full;
  assign w_ovf_clr  = MemWrite && w_hit_st && WriteData[2];
  assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_cnt5     = 5'(w_count);
  assign w_unused_bits = &{1'b0, WriteData[31:8]};

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_din   (WriteData[7:0]),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset)          r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state plus pop/shift strobes; every transition lands on a baud end.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: if (w_baud_end) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_baud_end) begin
          w_shift = 1'b1;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: if (w_baud_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Baud counter and bit index; both restart at every state or bit change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud <= '0;
      r_bit  <= '0;
    end else begin
      if (r_state == S_IDLE || w_baud_end) r_baud <= '0;
      else                                 r_baud <= r_baud + 1'b1;
      if (r_state != S_DATA) r_bit <= '0;
      else if (w_shift)      r_bit <= r_bit + 1'b1;
    end
  end

  // Shift register: load the FIFO head on pop, shift right at each data-bit end.
  always_ff @(posedge clk) begin
    if (w_pop)        r_shreg <= w_fifo_dout;
    else if (w_shift) r_shreg <= {1'b0, r_shreg[7:1]};
  end

  // Line and busy are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_busy <= (r_state != S_IDLE);
      case (r_state)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= r_shreg[0];
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;

  // Status word assembled from registered state only.
  always_comb begin
    StatusData                         = '0;
    StatusData[ST_FULL]                = w_full;
    StatusData[ST_EMPTY]               = w_empty;
    StatusData[ST_OVF]                 = r_ovf;
    StatusData[ST_BUSY]                = r_busy;
    StatusData[ST_CNT_LSB +: 4]        = w_cnt5[3:0];
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle RISC-V core's data bus, beside `dmem`. Snoops the core's store interface (`MemWrite`, `DataAdr`, `WriteData`) and buffers bytes stored to its TX address in a small FIFO. Serialises the bytes as 8N1 frames on `tx`. Exposes a status word that the top level muxes into `ReadData` when `Sel` is high.

## Interface
- `TX_ADDR`, default 32'hFFFF_0000: store here pushes `WriteData[7:0]` into the FIFO.
- `STATUS_ADDR`, default 32'hFFFF_0004: status read address; stores here clear sticky flags.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, default 8: FIFO entries; power of two, 2–16.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `MemWrite`  in  1: store strobe from the core.
- `DataAdr`  in  32: byte address from the core.
- `WriteData`  in  32: store data from the core.
- `Sel`  out  1: combinational; 1 when `DataAdr` == `TX_ADDR` or `STATUS_ADDR`.
- `StatusData`  out  32: combinational status word, independent of `DataAdr`.
- `tx`  out  1: serial line, registered, idle high.
- `busy`  out  1: registered; 1 while the FSM is outside S_IDLE.

## Operation
- Address match is an exact 32-bit compare. Stores to any other address are ignored.
- Push: `MemWrite`=1 and `DataAdr`==`TX_ADDR`. `WriteData[31:8]` is ignored.
  - If the FIFO is not full, `WriteData[7:0]` is written into it.
  - If the FIFO is full, the byte is dropped and `overflow` is set.
  - `full` is evaluated before the same-cycle pop. A push while full is always dropped, even if a pop happens that cycle.
- Clear: a store to `STATUS_ADDR` with `WriteData[2]`=1 clears `overflow`. A clear and a new overflow in the same cycle leave `overflow`=1 (set wins).
- StatusData fields:
  - bit0 `full`
  - bit1 `empty`
  - bit2 `overflow`
  - bit3 `busy`
  - bits[11:8] FIFO count
  - all other bits 0
- FSM states:
  - S_IDLE: `tx`=1. If the FIFO is non-empty, pop the head into an 8-bit shift register and go to S_START.
  - S_START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to S_DATA.
  - S_DATA: shift out 8 bits LSB first, `CLKS_PER_BIT` cycles each, using a 3-bit bit index. After bit 7, go to S_STOP.
  - S_STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to S_IDLE.
- Pop only in S_IDLE. A push to an empty FIFO is seen by the FSM on the next cycle; no bypass.
- The baud counter counts 0..`CLKS_PER_BIT`-1. It resets on every state or bit change.
- Reset, including mid-frame, at the next edge:
  - state S_IDLE, `tx`=1, `busy`=0
  - FIFO emptied, count 0, `overflow`=0
  - any in-flight byte is lost
  - `StatusData` = 32'h0000_0002

## Timing
- A store sampled at edge E is in the FIFO after E.
- The FSM pops in the cycle after E, so `tx` falls and `busy` rises after edge E+2.
- Frame length is 10×`CLKS_PER_BIT` cycles of `busy`=1.
- Back-to-back bytes: one S_IDLE cycle between frames. Start-bit falling edges are 10×`CLKS_PER_BIT`+1 cycles apart.
- `StatusData` and `Sel` are combinational from registers and `DataAdr`. The core sees the status in the same cycle as its load.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t`
  - localparams for status bit indices (`ST_FULL`=0, `ST_EMPTY`=1, `ST_OVF`=2, `ST_BUSY`=3, `ST_CNT_LSB`=8)
- Sub-module `uart_fifo`: synchronous FIFO parameterised on width and depth.
  - Interface: push, pop, din, dout, full, empty, count.
  - Wrap-around pointers with an extra bit for the full/empty distinction.
  - Synchronous reset.
- Top `mmio_uart_tx` contains: address decode, overflow flag, FSM, baud counter, shift register.

## Test plan
Benches run with `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=8.
- Reset: hold `reset` for 2 cycles → `tx`=1, `busy`=0, `StatusData`=32'h0000_0002, `Sel`=0 for `DataAdr`=0.
- Single byte: store 32'hABCD_1255 to `TX_ADDR` → `tx` falls 2 edges later. Then the line carries start 0, data bits 1,0,1,0,1,0,1,0 and stop 1, each 4 cycles. `busy` is high for exactly 40 cycles.
- Overflow: 10 stores of 0x00..0x09 on consecutive cycles → 0x00..0x08 accepted and 0x09 dropped. Then `StatusData` bits = `full`1, `overflow`1, count 8. Bytes are transmitted in order 0x00..0x08 with start edges 41 cycles apart.
- Clear: store 32'h4 to `STATUS_ADDR` → `overflow`=0, other status bits unchanged. A store of 32'h0 to `STATUS_ADDR` changes nothing.
- Reset mid-frame: assert `reset` during data bit 3 with 2 bytes queued → after the next edge `tx`=1, `busy`=0, count 0. No further frames appear.
- Decode: store to 32'h0000_0100 and to 32'hFFFF_0001 → FIFO unchanged, `Sel`=0. `Sel`=1 for `DataAdr` = 32'hFFFF_0004.
